// File: rtl/miner_pkg.sv
// Shared types for the compression scheduler: hash words, the scheduler state
// encoding and the per-block round count.
package miner_pkg;

  localparam int ROUNDS = 64;
  localparam int CNT_W  = 6;

  typedef logic [31:0] word_t;
  typedef word_t [7:0] hash_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_FINAL  = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

  // Word-wise modulo-2^32 sum used for the feed-forward of the chaining value.
  function automatic hash_t hash_add(input hash_t a, input hash_t b);
    hash_t s;
    for (int i = 0; i < 8; i++) begin
      s[i] = a[i] + b[i];
    end
    return s;
  endfunction

endpackage

// File: rtl/miner_rr_arb.sv
// Two-way round-robin arbiter: ptr_i names the requester that wins a tie,
// a lone request always wins.
module miner_rr_arb (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] win_o
);

  always_comb begin
    win_o = 2'b00;
    if (ptr_i == 1'b0) begin
      if (req_i[0])      win_o = 2'b01;
      else if (req_i[1]) win_o = 2'b10;
    end else begin
      if (req_i[1])      win_o = 2'b10;
      else if (req_i[0]) win_o = 2'b01;
    end
  end

endmodule

// File: rtl/miner_comp_sched.sv
// Shares one SHA-256 compression core between two requesters: grants round-robin,
// launches the core, performs the final chaining add and holds the digest until taken.
module miner_comp_sched
  import miner_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ROUNDS = miner_pkg::ROUNDS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  hash_t [NREQ-1:0]    req_first_h,
  output logic [NREQ-1:0]     grant,
  output logic                core_sel,
  output logic                comp_en,
  output hash_t               core_first_h,
  input  hash_t               core_h,
  output hash_t               digest,
  output logic                digest_valid,
  output logic                digest_id,
  input  logic                digest_ready,
  output logic                busy
);

  // RUN lasts ROUNDS-1 cycles; the counter is cleared in LAUNCH.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic             sel_q, sel_d;
  hash_t            first_h_q, first_h_d;
  hash_t            digest_q, digest_d;
  logic             dvalid_q, dvalid_d;
  logic             did_q, did_d;
  logic [1:0]       win;

  miner_rr_arb u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= 1'b0;
      sel_q     <= 1'b0;
      first_h_q <= '0;
      digest_q  <= '0;
      dvalid_q  <= 1'b0;
      did_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      first_h_q <= first_h_d;
      digest_q  <= digest_d;
      dvalid_q  <= dvalid_d;
      did_q     <= did_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    first_h_d = first_h_q;
    digest_d  = digest_q;
    dvalid_d  = dvalid_q;
    did_d     = did_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|win) begin
          sel_d     = win[1];
          first_h_d = req_first_h[win[1]];
          state_d   = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        digest_d = hash_add(core_h, first_h_q);
        dvalid_d = 1'b1;
        did_d    = sel_q;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        // The requester just served loses the next tie.
        if (digest_ready) begin
          dvalid_d = 1'b0;
          ptr_d    = ~did_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant is combinational from IDLE so the core starts the very next cycle;
  // rst masks it so reset forces it low immediately.
  assign grant        = (state_q == ST_IDLE && !rst) ? win : '0;
  assign comp_en      = (state_q == ST_LAUNCH);
  assign core_sel     = sel_q;
  assign core_first_h = first_h_q;
  assign digest       = digest_q;
  assign digest_valid = dvalid_q;
  assign digest_id    = did_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_miner_comp_sched.sv
// Directed bench for miner_comp_sched with a behavioural SHA-256 core and a
// constant-output stub core selectable per scenario.
module tb_miner_comp_sched;
  import miner_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  hash_t [1:0] req_first_h;
  logic [1:0]  grant;
  logic        core_sel;
  logic        comp_en;
  hash_t       core_first_h;
  hash_t       core_h;
  hash_t       digest;
  logic        digest_valid;
  logic        digest_id;
  logic        digest_ready;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic        use_stub;
  hash_t       stub_h, sha_h;
  int          t_q;
  logic [31:0] K [64];
  logic [31:0] wsched [2][64];
  hash_t       iv_h, abc_h, wrap_first, wrap_exp;

  miner_comp_sched #(.NREQ(2), .ROUNDS(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_first_h  (req_first_h),
    .grant        (grant),
    .core_sel     (core_sel),
    .comp_en      (comp_en),
    .core_first_h (core_first_h),
    .core_h       (core_h),
    .digest       (digest),
    .digest_valid (digest_valid),
    .digest_id    (digest_id),
    .digest_ready (digest_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic hash_t sha_round(input hash_t s, input logic [31:0] w, input logic [31:0] k);
    hash_t r;
    logic [31:0] t1, t2;
    t1 = s[7] + (ror(s[4], 6) ^ ror(s[4], 11) ^ ror(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2 = (ror(s[0], 2) ^ ror(s[0], 13) ^ ror(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    r[0] = t1 + t2; r[1] = s[0]; r[2] = s[1]; r[3] = s[2];
    r[4] = s[3] + t1; r[5] = s[4]; r[6] = s[5]; r[7] = s[6];
    return r;
  endfunction

  // Behavioural core: round 0 on the comp_en edge, rounds 1..63 on the following edges.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sha_h <= '0;
      t_q   <= 0;
    end else if (comp_en) begin
      sha_h <= sha_round(core_first_h, wsched[core_sel][0], K[0]);
      t_q   <= 1;
    end else if (t_q > 0 && t_q < 64) begin
      sha_h <= sha_round(sha_h, wsched[core_sel][t_q], K[t_q]);
      t_q   <= t_q + 1;
    end
  end

  assign core_h = use_stub ? stub_h : sha_h;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input int limit);
    int n = 0;
    while (digest_valid !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (digest_valid !== 1'b1) begin failures++; $display("FAIL wait_valid got=%b exp=1 after %0d cycles", digest_valid, n); end
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL wait_idle busy got=%b exp=0 after %0d cycles", busy, n); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b11; digest_ready = 1'b0;
    step(); step();
    checks++; if (grant !== 2'b00)      begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++; if (comp_en !== 1'b0)     begin failures++; $display("FAIL reset_comp_en got=%b exp=0", comp_en); end
    checks++; if (core_sel !== 1'b0)    begin failures++; $display("FAIL reset_core_sel got=%b exp=0", core_sel); end
    checks++; if (core_first_h !== '0)  begin failures++; $display("FAIL reset_core_first_h got=%h exp=0", core_first_h); end
    checks++; if (digest !== '0)        begin failures++; $display("FAIL reset_digest got=%h exp=0", digest); end
    checks++; if (digest_valid !== 1'b0) begin failures++; $display("FAIL reset_digest_valid got=%b exp=0", digest_valid); end
    checks++; if (digest_id !== 1'b0)   begin failures++; $display("FAIL reset_digest_id got=%b exp=0", digest_id); end
    checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    req = 2'b00; rst = 1'b0;
    step();
  endtask

  task automatic test_abc();
    int gedge, pulses;
    use_stub = 1'b0; req_first_h[0] = iv_h; digest_ready = 1'b0;
    req = 2'b01; #1;
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL abc_grant got=%b exp=01", grant); end
    gedge = cyc + 1;
    step(); req = 2'b00;
    checks++; if (comp_en !== 1'b1)      begin failures++; $display("FAIL abc_comp_en got=%b exp=1", comp_en); end
    checks++; if (core_first_h !== iv_h) begin failures++; $display("FAIL abc_core_first_h got=%h exp=%h", core_first_h, iv_h); end
    checks++; if (grant !== 2'b00)       begin failures++; $display("FAIL abc_grant_pulse got=%b exp=00", grant); end
    pulses = 1;
    for (int n = 0; n < 100; n++) begin
      step();
      if (comp_en === 1'b1) pulses++;
      if (digest_valid === 1'b1) break;
    end
    checks++; if (pulses != 1)          begin failures++; $display("FAIL abc_comp_en_pulses got=%0d exp=1", pulses); end
    checks++; if (cyc - gedge != 65)    begin failures++; $display("FAIL abc_latency got=%0d exp=65", cyc - gedge); end
    checks++; if (digest !== abc_h)     begin failures++; $display("FAIL abc_digest got=%h exp=%h", digest, abc_h); end
    checks++; if (digest_id !== 1'b0)   begin failures++; $display("FAIL abc_digest_id got=%b exp=0", digest_id); end
    checks++; if (busy !== 1'b1)        begin failures++; $display("FAIL abc_busy_out got=%b exp=1", busy); end
    digest_ready = 1'b1;
    step();
    checks++; if (digest_valid !== 1'b0) begin failures++; $display("FAIL abc_valid_clear got=%b exp=0", digest_valid); end
    checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL abc_busy_idle got=%b exp=0", busy); end
    digest_ready = 1'b0;
  endtask

  task automatic test_wrap();
    use_stub = 1'b1; req_first_h[1] = wrap_first; digest_ready = 1'b1;
    req = 2'b10; #1;
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL wrap_grant got=%b exp=10", grant); end
    step(); req = 2'b00;
    checks++; if (core_sel !== 1'b1) begin failures++; $display("FAIL wrap_core_sel got=%b exp=1", core_sel); end
    wait_valid(100);
    checks++; if (digest !== wrap_exp)  begin failures++; $display("FAIL wrap_digest got=%h exp=%h", digest, wrap_exp); end
    checks++; if (digest_id !== 1'b1)   begin failures++; $display("FAIL wrap_digest_id got=%b exp=1", digest_id); end
    step();
    checks++; if (digest_valid !== 1'b0) begin failures++; $display("FAIL wrap_single_out got=%b exp=0", digest_valid); end
    checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL wrap_busy got=%b exp=0", busy); end
    digest_ready = 1'b0;
  endtask

  task automatic test_rr();
    logic [1:0] gr [4];
    logic       ids [4];
    int         gcyc [4];
    int         vcyc [4];
    hash_t      dig1;
    int         ng = 0;
    int         nv = 0;
    rst = 1'b1; step(); step();
    use_stub = 1'b1; req_first_h[0] = iv_h; req_first_h[1] = wrap_first;
    digest_ready = 1'b1; req = 2'b11; dig1 = '0;
    rst = 1'b0; #1;
    for (int n = 0; n < 400 && nv < 4; n++) begin
      if (ng == 4) req = 2'b00;
      if (grant !== 2'b00 && ng < 4) begin gr[ng] = grant; gcyc[ng] = cyc; ng++; end
      if (digest_valid === 1'b1 && nv < 4) begin
        ids[nv] = digest_id; vcyc[nv] = cyc;
        if (nv == 1) dig1 = digest;
        nv++;
      end
      step();
    end
    req = 2'b00;
    checks++; if (ng != 4 || nv != 4) begin failures++; $display("FAIL rr_count got grants=%0d digests=%0d exp=4/4", ng, nv); end
    for (int k = 0; k < 4 && k < ng && k < nv; k++) begin
      checks++; if (gr[k] !== ((k % 2) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", k, gr[k], (k % 2) ? 2'b10 : 2'b01); end
      checks++; if (ids[k] !== ((k % 2) ? 1'b1 : 1'b0))  begin failures++; $display("FAIL rr_id%0d got=%b exp=%0d", k, ids[k], k % 2); end
      if (k > 0) begin
        checks++; if (gcyc[k] - vcyc[k-1] != 1) begin failures++; $display("FAIL rr_gap%0d got=%0d exp=1", k, gcyc[k] - vcyc[k-1]); end
      end
    end
    checks++; if (dig1 !== wrap_exp) begin failures++; $display("FAIL rr_digest1 got=%h exp=%h", dig1, wrap_exp); end
    wait_idle(100);
  endtask

  task automatic test_stall();
    hash_t cap;
    use_stub = 1'b1; digest_ready = 1'b0;
    req = 2'b01; #1;
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL stall_grant0 got=%b exp=01", grant); end
    step(); req = 2'b00;
    wait_valid(100);
    cap = digest;
    req = 2'b11;
    for (int n = 0; n < 10; n++) begin
      step();
      checks++;
      if (digest !== cap || digest_valid !== 1'b1 || busy !== 1'b1 || grant !== 2'b00) begin
        failures++;
        $display("FAIL stall_hold%0d got digest=%h valid=%b busy=%b grant=%b exp digest=%h valid=1 busy=1 grant=00", n, digest, digest_valid, busy, grant, cap);
      end
    end
    digest_ready = 1'b1;
    step();
    checks++; if (digest_valid !== 1'b0) begin failures++; $display("FAIL stall_valid_clear got=%b exp=0", digest_valid); end
    checks++; if (grant !== 2'b10)       begin failures++; $display("FAIL stall_next_grant got=%b exp=10", grant); end
    step(); req = 2'b00;
    wait_idle(100);
  endtask

  task automatic test_midreset();
    int nv = 0;
    use_stub = 1'b1; digest_ready = 1'b0;
    req = 2'b10; #1;
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL mrst_grant got=%b exp=10", grant); end
    step(); req = 2'b00;
    repeat (31) step();
    checks++; if (core_sel !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL mrst_pre got core_sel=%b busy=%b exp=1/1", core_sel, busy); end
    req = 2'b11; #2;
    rst = 1'b1; #1;
    checks++; if (grant !== 2'b00)       begin failures++; $display("FAIL mrst_grant0 got=%b exp=00", grant); end
    checks++; if (comp_en !== 1'b0)      begin failures++; $display("FAIL mrst_comp_en got=%b exp=0", comp_en); end
    checks++; if (core_sel !== 1'b0)     begin failures++; $display("FAIL mrst_core_sel got=%b exp=0", core_sel); end
    checks++; if (core_first_h !== '0)   begin failures++; $display("FAIL mrst_core_first_h got=%h exp=0", core_first_h); end
    checks++; if (digest !== '0)         begin failures++; $display("FAIL mrst_digest got=%h exp=0", digest); end
    checks++; if (digest_valid !== 1'b0) begin failures++; $display("FAIL mrst_valid got=%b exp=0", digest_valid); end
    checks++; if (digest_id !== 1'b0)    begin failures++; $display("FAIL mrst_id got=%b exp=0", digest_id); end
    checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL mrst_busy got=%b exp=0", busy); end
    step(); step();
    rst = 1'b0; req = 2'b00;
    repeat (80) begin
      step();
      if (digest_valid === 1'b1) nv++;
    end
    checks++; if (nv != 0) begin failures++; $display("FAIL mrst_no_digest got=%0d valid cycles exp=0", nv); end
    use_stub = 1'b0; req_first_h[0] = iv_h;
    req = 2'b01; #1;
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL mrst_fresh_grant got=%b exp=01", grant); end
    step(); req = 2'b00;
    wait_valid(100);
    checks++; if (digest !== abc_h)   begin failures++; $display("FAIL mrst_fresh_digest got=%h exp=%h", digest, abc_h); end
    checks++; if (digest_id !== 1'b0) begin failures++; $display("FAIL mrst_fresh_id got=%b exp=0", digest_id); end
    digest_ready = 1'b1;
    wait_idle(10);
    digest_ready = 1'b0;
  endtask

  task automatic test_ignore();
    logic seen = 1'b0;
    int   n = 0;
    use_stub = 1'b1; digest_ready = 1'b1;
    req = 2'b01; #1;
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL ign_grant got=%b exp=01", grant); end
    step(); req = 2'b00;
    repeat (20) step();
    req = 2'b10;
    repeat (3) begin
      if (grant[1] === 1'b1) seen = 1'b1;
      step();
    end
    req = 2'b00;
    while (busy === 1'b1 && n < 100) begin
      if (grant[1] === 1'b1) seen = 1'b1;
      step();
      n++;
    end
    repeat (5) begin
      if (grant[1] === 1'b1) seen = 1'b1;
      step();
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL ign_grant1 got=%b exp=0", seen); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_busy got=%b exp=0", busy); end
    digest_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; digest_ready = 1'b0; use_stub = 1'b0; req_first_h = '0;
    K = '{32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
          32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
          32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
          32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
          32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
          32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
          32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
          32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    // Both requesters supply the padded "abc" block as their message.
    for (int r = 0; r < 2; r++) begin
      for (int t = 0; t < 16; t++) wsched[r][t] = 32'h0;
      wsched[r][0]  = 32'h61626380;
      wsched[r][15] = 32'h00000018;
      for (int t = 16; t < 64; t++) begin
        wsched[r][t] = (ror(wsched[r][t-2], 17) ^ ror(wsched[r][t-2], 19) ^ (wsched[r][t-2] >> 10))
                     + wsched[r][t-7]
                     + (ror(wsched[r][t-15], 7) ^ ror(wsched[r][t-15], 18) ^ (wsched[r][t-15] >> 3))
                     + wsched[r][t-16];
      end
    end
    iv_h       = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                  32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
    abc_h      = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                  32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
    stub_h     = {32'h70000000, 32'h60000000, 32'h50000000, 32'h40000000,
                  32'h30000000, 32'h20000000, 32'h10000000, 32'hffffffff};
    wrap_first = {32'h00000007, 32'h00000006, 32'h00000005, 32'h00000004,
                  32'h00000003, 32'h00000002, 32'h00000001, 32'h00000002};
    wrap_exp   = {32'h70000007, 32'h60000006, 32'h50000005, 32'h40000004,
                  32'h30000003, 32'h20000002, 32'h10000001, 32'h00000001};

    test_reset();
    test_abc();
    test_wrap();
    test_rr();
    test_stall();
    test_midreset();
    test_ignore();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
